// File: rtl/cdb_writeback.sv
// Common-data-bus writeback: captures FU results per ROB tag and tracks which tags hold a result.
// Each tag owns a cdb_slot that resolves alloc/commit/flush/write priority for that entry.
module cdb_slot #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 3,
  parameter int TAG    = 0
) (
  input  logic [NUM_FU-1:0]            fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0] fu_tag,
  input  logic [NUM_FU-1:0][31:0]      fu_wdata,
  input  logic [NUM_FU-1:0]            fu_wbr,
  input  logic                         flush,
  input  logic                         alloc_hit,
  input  logic                         commit_hit,
  input  logic                         calc_q,
  input  logic                         br_q,
  input  logic [31:0]                  data_q,
  output logic                         calc_d,
  output logic                         br_d,
  output logic [31:0]                  data_d,
  output logic                         conflict
);
  localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(TAG);

  logic [NUM_FU-1:0] hit;
  logic [31:0]       sel_data;
  logic              sel_br;
  logic              any_hit;
  logic              multi_hit;

  // Walk high to low so the lowest-index FU is the last (winning) assignment.
  always_comb begin
    hit      = '0;
    sel_data = '0;
    sel_br   = 1'b0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (fu_valid[i] && fu_tag[i] == MY_TAG) begin
        hit[i]   = 1'b1;
        sel_data = fu_wdata[i];
        sel_br   = fu_wbr[i];
      end
    end
  end

  assign any_hit   = |hit;
  assign multi_hit = (hit & (hit - NUM_FU'(1))) != '0;

  always_comb begin
    calc_d   = calc_q;
    br_d     = br_q;
    data_d   = data_q;
    conflict = 1'b0;
    if (flush) begin
      calc_d = 1'b0;
    end else if (alloc_hit) begin
      // A write racing a fresh allocation belongs to the previous owner: drop silently.
      calc_d = 1'b0;
      data_d = '0;
      br_d   = 1'b0;
    end else if (commit_hit) begin
      calc_d   = 1'b0;
      conflict = any_hit;
    end else if (any_hit) begin
      calc_d   = 1'b1;
      data_d   = sel_data;
      br_d     = sel_br;
      conflict = multi_hit | calc_q;
    end
  end
endmodule

module cdb_writeback #(
  parameter int NUM_FU    = 4,
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_FU-1:0]               fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU-1:0][31:0]         fu_result,
  input  logic [NUM_FU-1:0][31:0]         fu_pc,
  input  logic [NUM_FU-1:0]               fu_ld_pc,
  input  logic [NUM_FU-1:0]               fu_update_br,
  input  logic                            alloc_valid,
  input  logic [TAG_W-1:0]                alloc_tag,
  input  logic                            commit_valid,
  input  logic [TAG_W-1:0]                commit_tag,
  input  logic                            flush,
  output logic [ROB_DEPTH-1:0][31:0]      cdb_data,
  output logic [ROB_DEPTH-1:0]            cdb_br_taken,
  output logic [ROB_DEPTH-1:0]            robs_calculated,
  output logic [TAG_W:0]                  calc_count,
  output logic                            wb_conflict,
  output logic [TAG_W-1:0]                conflict_tag
);
  logic [NUM_FU-1:0][31:0]    fu_wdata;
  logic [NUM_FU-1:0]          fu_wbr;

  logic [ROB_DEPTH-1:0][31:0] data_q, data_d;
  logic [ROB_DEPTH-1:0]       br_q, br_d;
  logic [ROB_DEPTH-1:0]       calc_q, calc_d;
  logic [ROB_DEPTH-1:0]       slot_conf;
  logic [TAG_W:0]             count_q, count_d;
  logic                       conf_q, conf_d;
  logic [TAG_W-1:0]           ctag_q, ctag_d;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign fu_wdata[i] = fu_ld_pc[i] ? fu_pc[i] + 32'd4 : fu_result[i];
    assign fu_wbr[i]   = fu_update_br[i] & fu_result[i][0];
  end

  for (genvar t = 0; t < ROB_DEPTH; t++) begin : g_slot
    cdb_slot #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .TAG(t)) u_slot (
      .fu_valid  (fu_valid),
      .fu_tag    (fu_tag),
      .fu_wdata  (fu_wdata),
      .fu_wbr    (fu_wbr),
      .flush     (flush),
      .alloc_hit (alloc_valid && alloc_tag == TAG_W'(t)),
      .commit_hit(commit_valid && commit_tag == TAG_W'(t)),
      .calc_q    (calc_q[t]),
      .br_q      (br_q[t]),
      .data_q    (data_q[t]),
      .calc_d    (calc_d[t]),
      .br_d      (br_d[t]),
      .data_d    (data_d[t]),
      .conflict  (slot_conf[t])
    );
  end

  // Count the next-state vector so the registered count tracks robs_calculated exactly.
  always_comb begin
    count_d = '0;
    for (int t = 0; t < ROB_DEPTH; t++) count_d = count_d + (TAG_W+1)'(calc_d[t]);
    conf_d = |slot_conf;
    ctag_d = ctag_q;
    for (int t = ROB_DEPTH - 1; t >= 0; t--) begin
      if (slot_conf[t]) ctag_d = TAG_W'(t);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      br_q    <= '0;
      calc_q  <= '0;
      count_q <= '0;
      conf_q  <= 1'b0;
      ctag_q  <= '0;
    end else begin
      data_q  <= data_d;
      br_q    <= br_d;
      calc_q  <= calc_d;
      count_q <= count_d;
      conf_q  <= conf_d;
      ctag_q  <= ctag_d;
    end
  end

  assign cdb_data        = data_q;
  assign cdb_br_taken    = br_q;
  assign robs_calculated = calc_q;
  assign calc_count      = count_q;
  assign wb_conflict     = conf_q;
  assign conflict_tag    = ctag_q;
endmodule

// File: tb/tb_cdb_writeback.sv
// Bench for cdb_writeback: directed vector table followed by random traffic against a rule-level model.
module tb_cdb_writeback;
  logic clk, rst;
  logic [3:0]       fu_valid, fu_ld_pc, fu_update_br;
  logic [3:0][2:0]  fu_tag;
  logic [3:0][31:0] fu_result, fu_pc;
  logic alloc_valid, commit_valid, flush;
  logic [2:0] alloc_tag, commit_tag;
  logic [7:0][31:0] cdb_data;
  logic [7:0] cdb_br_taken, robs_calculated;
  logic [3:0] calc_count;
  logic wb_conflict;
  logic [2:0] conflict_tag;

  cdb_writeback #(.NUM_FU(4), .ROB_DEPTH(8), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_result(fu_result),
    .fu_pc(fu_pc), .fu_ld_pc(fu_ld_pc), .fu_update_br(fu_update_br),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .commit_valid(commit_valid),
    .commit_tag(commit_tag), .flush(flush), .cdb_data(cdb_data), .cdb_br_taken(cdb_br_taken),
    .robs_calculated(robs_calculated), .calc_count(calc_count), .wb_conflict(wb_conflict),
    .conflict_tag(conflict_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]       fv;
    logic [3:0][2:0]  tag;
    logic [3:0][31:0] res;
    logic [3:0][31:0] pc;
    logic [3:0]       ldpc;
    logic [3:0]       updbr;
    logic             av;
    logic [2:0]       at;
    logic             cv;
    logic [2:0]       ct;
    logic             fl;
    logic             rs;
    logic [7:0]       e_calc;
    logic [3:0]       e_cnt;
    logic             e_conf;
    logic [2:0]       e_ctag;
    logic [2:0]       p_tag;
    logic [31:0]      p_data;
    logic             p_br;
  } vec_t;

  function automatic vec_t wr(vec_t v, int fu, int tag, logic [31:0] res);
    v.fv[fu]  = 1'b1;
    v.tag[fu] = 3'(tag);
    v.res[fu] = res;
    return v;
  endfunction

  function automatic vec_t ex(vec_t v, logic [7:0] calc, int cnt, logic conf, int ctag,
                              int ptag, logic [31:0] pdata, logic pbr);
    v.e_calc = calc; v.e_cnt = 4'(cnt); v.e_conf = conf; v.e_ctag = 3'(ctag);
    v.p_tag = 3'(ptag); v.p_data = pdata; v.p_br = pbr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    fu_valid = v.fv; fu_tag = v.tag; fu_result = v.res; fu_pc = v.pc;
    fu_ld_pc = v.ldpc; fu_update_br = v.updbr;
    alloc_valid = v.av; alloc_tag = v.at; commit_valid = v.cv; commit_tag = v.ct;
    flush = v.fl; rst = v.rs;
  endtask

  // Reference state: one record per ROB tag.
  logic [31:0] m_data [8];
  logic        m_br   [8];
  logic        m_calc [8];
  logic        m_conf;
  logic [2:0]  m_ctag;

  task automatic model_step();
    int writers[$];
    logic found;
    if (rst) begin
      for (int t = 0; t < 8; t++) begin m_data[t] = 0; m_br[t] = 0; m_calc[t] = 0; end
      m_conf = 0; m_ctag = 0;
      return;
    end
    m_conf = 0;
    if (flush) begin
      for (int t = 0; t < 8; t++) m_calc[t] = 0;
      return;
    end
    found = 0;
    for (int t = 0; t < 8; t++) begin
      logic cf;
      cf = 0;
      writers.delete();
      for (int f = 0; f < 4; f++)
        if (fu_valid[f] && int'(fu_tag[f]) == t) writers.push_back(f);
      if (alloc_valid && int'(alloc_tag) == t) begin
        m_calc[t] = 0; m_data[t] = 0; m_br[t] = 0;
      end else if (commit_valid && int'(commit_tag) == t) begin
        m_calc[t] = 0;
        cf = writers.size() > 0;
      end else if (writers.size() > 0) begin
        int w;
        w = writers[0];
        cf = writers.size() > 1 || m_calc[t];
        m_data[t] = fu_ld_pc[w] ? fu_pc[w] + 32'd4 : fu_result[w];
        m_br[t] = fu_update_br[w] && fu_result[w][0];
        m_calc[t] = 1;
      end
      if (cf) begin
        m_conf = 1;
        if (!found) begin m_ctag = 3'(t); found = 1; end
      end
    end
  endtask

  task automatic check_model();
    logic [7:0] calc, br;
    int cnt;
    cnt = 0;
    for (int t = 0; t < 8; t++) begin
      calc[t] = m_calc[t]; br[t] = m_br[t]; cnt += int'(m_calc[t]);
      chk($sformatf("rand_data[%0d]", t), cdb_data[t], m_data[t]);
    end
    chk("rand_calc", 32'(robs_calculated), 32'(calc));
    chk("rand_br", 32'(cdb_br_taken), 32'(br));
    chk("rand_count", 32'(calc_count), 32'(cnt));
    chk("rand_conf", 32'(wb_conflict), 32'(m_conf));
    chk("rand_ctag", 32'(conflict_tag), 32'(m_ctag));
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    v = '0;
    v.rs = 1'b1;
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_calc", 32'(robs_calculated), 0);
    chk("reset_count", 32'(calc_count), 0);
    chk("reset_conf", 32'(wb_conflict), 0);
    chk("reset_data3", cdb_data[3], 0);

    // 1 single write
    v = wr('0, 0, 3, 32'hDEADBEEF);
    vecs.push_back(ex(v, 8'h08, 1, 0, 0, 3, 32'hDEADBEEF, 0));
    // 2 jalr path with branch taken
    v = wr('0, 1, 5, 32'd1); v.pc[1] = 32'h40000010; v.ldpc[1] = 1; v.updbr[1] = 1;
    vecs.push_back(ex(v, 8'h28, 2, 0, 0, 5, 32'h40000014, 1));
    // 3 pc+4 wraps
    v = wr('0, 1, 7, 32'd1); v.pc[1] = 32'hFFFFFFFC; v.ldpc[1] = 1; v.updbr[1] = 1;
    vecs.push_back(ex(v, 8'hA8, 3, 0, 0, 7, 32'h0, 1));
    // 4 collision, lowest FU wins
    v = wr(wr('0, 0, 2, 32'h11), 2, 2, 32'h22);
    vecs.push_back(ex(v, 8'hAC, 4, 1, 2, 2, 32'h11, 0));
    // 5 idle: pulse ends, conflict_tag holds
    vecs.push_back(ex('0, 8'hAC, 4, 0, 2, 2, 32'h11, 0));
    // 6 commit racing write
    v = wr('0, 0, 4, 32'h44); v.cv = 1; v.ct = 4;
    vecs.push_back(ex(v, 8'hAC, 4, 1, 4, 4, 32'h0, 0));
    // 7 alloc racing write: dropped quietly
    v = wr('0, 3, 6, 32'h66); v.av = 1; v.at = 6;
    vecs.push_back(ex(v, 8'hAC, 4, 0, 4, 6, 32'h0, 0));
    // 8 alloc clears a written entry
    v = '0; v.av = 1; v.at = 3;
    vecs.push_back(ex(v, 8'hA4, 3, 0, 4, 3, 32'h0, 0));
    // 9 commit keeps data
    v = '0; v.cv = 1; v.ct = 2;
    vecs.push_back(ex(v, 8'hA0, 2, 0, 4, 2, 32'h11, 0));
    // 10 alloc and commit same tag: alloc clears taken bit
    v = '0; v.av = 1; v.at = 7; v.cv = 1; v.ct = 7;
    vecs.push_back(ex(v, 8'h20, 1, 0, 4, 7, 32'h0, 0));
    // 11-12 fill all tags, tag 2 rewritten after set -> conflict
    v = wr(wr(wr(wr('0, 0, 0, 32'h100), 1, 1, 32'h101), 2, 2, 32'h102), 3, 3, 32'h103);
    vecs.push_back(ex(v, 8'h2F, 5, 0, 4, 1, 32'h101, 0));
    v = wr(wr(wr(wr('0, 0, 4, 32'h104), 1, 6, 32'h106), 2, 7, 32'h107), 3, 2, 32'h202);
    vecs.push_back(ex(v, 8'hFF, 8, 1, 2, 2, 32'h202, 0));
    // 13 flush drops a write, data retained
    v = wr('0, 0, 1, 32'h999); v.fl = 1;
    vecs.push_back(ex(v, 8'h00, 0, 0, 2, 1, 32'h101, 0));
    // 14 write after flush is clean
    v = wr('0, 0, 5, 32'h55);
    vecs.push_back(ex(v, 8'h20, 1, 0, 2, 5, 32'h55, 0));
    // 15 reset overrides writes
    v = wr(wr(wr('0, 0, 0, 32'h1), 1, 1, 32'h2), 2, 2, 32'h3); v.rs = 1;
    vecs.push_back(ex(v, 8'h00, 0, 0, 0, 5, 32'h0, 0));

    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_calc", k), 32'(robs_calculated), 32'(vecs[k].e_calc));
      chk($sformatf("v%0d_count", k), 32'(calc_count), 32'(vecs[k].e_cnt));
      chk($sformatf("v%0d_conf", k), 32'(wb_conflict), 32'(vecs[k].e_conf));
      chk($sformatf("v%0d_ctag", k), 32'(conflict_tag), 32'(vecs[k].e_ctag));
      chk($sformatf("v%0d_data", k), cdb_data[vecs[k].p_tag], vecs[k].p_data);
      chk($sformatf("v%0d_br", k), 32'(cdb_br_taken[vecs[k].p_tag]), 32'(vecs[k].p_br));
    end

    // DUT is in reset state here; start the model there too.
    for (int t = 0; t < 8; t++) begin m_data[t] = 0; m_br[t] = 0; m_calc[t] = 0; end
    m_conf = 0; m_ctag = 0;

    for (int c = 0; c < 400; c++) begin
      for (int f = 0; f < 4; f++) begin
        fu_valid[f]     = ($urandom_range(0, 1) == 1);
        fu_tag[f]       = 3'($urandom_range(0, 7));
        fu_result[f]    = $urandom;
        fu_pc[f]        = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
        fu_ld_pc[f]     = ($urandom_range(0, 3) == 0);
        fu_update_br[f] = ($urandom_range(0, 2) == 0);
      end
      alloc_valid  = ($urandom_range(0, 3) == 0);
      alloc_tag    = 3'($urandom_range(0, 7));
      commit_valid = ($urandom_range(0, 3) == 0);
      commit_tag   = 3'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 24) == 0);
      rst          = ($urandom_range(0, 49) == 0);
      model_step();
      @(posedge clk);
      #1;
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdb_writeback.md
# cdb_writeback

Result-broadcast stage directly downstream of the ALU/functional units fed by the reservation stations. Captures each unit's completed result into a per-ROB-tag common-data-bus array and maintains the `robs_calculated` bit vector. Reservation stations snoop both signals combinationally to wake up waiting operands. Entries are cleared on ROB allocate, commit, and flush; same-cycle write conflicts are flagged for debug.

## Interface
Parameters:
- `NUM_FU`, 4: number of functional-unit result ports.
- `ROB_DEPTH`, 8: number of ROB entries, which is also the number of CDB slots.
- `TAG_W`, 3: tag width, equal to `$clog2(ROB_DEPTH)`.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `fu_valid[NUM_FU]`, in, 1 each: unit has a result this cycle (the unit's `start_exe`).
- `fu_tag[NUM_FU]`, in, `TAG_W` each: destination ROB tag.
- `fu_result[NUM_FU]`, in, 32 each: ALU output.
- `fu_pc[NUM_FU]`, in, 32 each: instruction PC.
- `fu_ld_pc[NUM_FU]`, in, 1 each: broadcast `fu_pc+4` instead of `fu_result`.
- `fu_update_br[NUM_FU]`, in, 1 each: branch; record `fu_result[0]` as the taken bit.
- `alloc_valid`, in, 1: ROB allocating an entry.
- `alloc_tag`, in, `TAG_W`: tag of the entry being allocated.
- `commit_valid`, in, 1: ROB committing its head entry.
- `commit_tag`, in, `TAG_W`: tag of the entry being committed.
- `flush`, in, 1: pipeline flush.
- `cdb_data[ROB_DEPTH]`, out, 32 each: broadcast value per tag.
- `cdb_br_taken`, out, `ROB_DEPTH`: branch-taken bit per tag.
- `robs_calculated`, out, `ROB_DEPTH`: result present for each tag.
- `calc_count`, out, `TAG_W+1`: popcount of `robs_calculated`, registered.
- `wb_conflict`, out, 1: one-cycle pulse reporting an illegal write.
- `conflict_tag`, out, `TAG_W`: tag that caused the last conflict; holds until the next conflict.

## Operation
Write value selection:
- If `fu_ld_pc` is set, the written value is `fu_pc + 32'd4`, computed modulo 2^32 so it wraps silently.
- Otherwise the written value is `fu_result`.

Taken bit:
- On a write with `fu_update_br` set, `cdb_br_taken[tag]` takes `fu_result[0]`.
- On a write without `fu_update_br`, `cdb_br_taken[tag]` is cleared.

Per-tag update, evaluated every cycle with priority high to low:
- **rst:** clear all data, all taken bits, `robs_calculated`, `calc_count`, `wb_conflict`, and `conflict_tag`.
- **flush:** clear all of `robs_calculated`. `cdb_data` and `cdb_br_taken` are retained. All FU writes in the same cycle are dropped, and alloc/commit are ignored.
- **Allocate** (`alloc_valid` and tag == `alloc_tag`): clear the bit, data, and taken bit. A same-cycle FU write to that tag is dropped as stale, with no conflict raised.
- **Commit** (`commit_valid` and tag == `commit_tag`): clear the bit; data is retained. A same-cycle write to that tag is dropped, and `wb_conflict` pulses.
- **FU write:** set the bit and write the data and taken bit.

Multiple FUs targeting one tag in the same cycle:
- The lowest FU index wins.
- `wb_conflict` pulses and `conflict_tag` takes that tag.

Write to a tag whose bit is already set:
- The write is performed and overwrites the entry.
- `wb_conflict` pulses.

`alloc_tag == commit_tag` in the same cycle: allocate wins, and the entry is cleared.

Conflict reporting:
- If several conflicts occur in one cycle, `conflict_tag` reports the lowest tag.
- `calc_count` always equals the popcount of the registered `robs_calculated`, in the same cycle.

## Timing
- All outputs are registered.
- Writes are visible one cycle after `fu_valid`: the result is captured at edge N and appears on `cdb_data`/`robs_calculated` during cycle N+1. This lets the RS PEEK path see it that cycle.
- A clear takes effect at the edge where `alloc`/`commit`/`flush` is sampled.
- `wb_conflict` is high during exactly the cycle after the offending edge.
- There is no backpressure: every valid FU result is accepted or dropped in the cycle it is presented.
- Reset values: every output is 0.
- Reset asserted mid-operation overrides all simultaneous inputs.

## Test plan
- **Single write:** FU0 valid, tag 3, result 0xDEADBEEF → next cycle `cdb_data[3]`=0xDEADBEEF, `robs_calculated`=8'b0000_1000, `calc_count`=1.
- **JALR/branch path:** FU1 valid, tag 5, `ld_pc`=1, `update_br`=1, pc 0x40000010, result 1 → `cdb_data[5]`=0x40000014, `cdb_br_taken[5]`=1. Also pc 0xFFFFFFFC → 0x00000000.
- **Collision:** FU0 and FU2 both write tag 2 (values 0x11, 0x22) → `cdb_data[2]`=0x11, `wb_conflict`=1 for one cycle, `conflict_tag`=2.
- **Clear races:**
  - Commit tag 4 plus FU write tag 4 → bit 4 stays 0 and `wb_conflict` pulses.
  - Alloc tag 6 plus write tag 6 → bit 6 is 0, data 0, no conflict.
- **Flush:** fill tags 0–7, then assert `flush` together with an FU write to tag 1 → `robs_calculated`=0, `calc_count`=0, `cdb_data` unchanged.
- **Reset mid-stream:** assert `rst` while 3 FUs write → all outputs 0 on the next cycle.
